// File: rtl/wb_reg_file_if.sv
// Write-back register file bus: MEM/WB write port plus two ID read ports.
// Master is the pipeline side, slave is the register file.
interface wb_reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              RegWrite_in;
  logic [ADDR_W-1:0] RdAddr_in;
  logic [DATA_W-1:0] WrData_in;
  logic [ADDR_W-1:0] RsAddr_in;
  logic [ADDR_W-1:0] RtAddr_in;
  logic [DATA_W-1:0] RsData_out;
  logic [DATA_W-1:0] RtData_out;
  logic              RsUninit_out;
  logic              RtUninit_out;
  logic [CNT_W-1:0]  WrCount_out;

  modport master (
    output RegWrite_in, RdAddr_in, WrData_in,
    output RsAddr_in, RtAddr_in,
    input  RsData_out, RtData_out,
    input  RsUninit_out, RtUninit_out,
    input  WrCount_out
  );

  modport slave (
    input  RegWrite_in, RdAddr_in, WrData_in,
    input  RsAddr_in, RtAddr_in,
    output RsData_out, RtData_out,
    output RsUninit_out, RtUninit_out,
    output WrCount_out
  );
endinterface

// File: rtl/wb_reg_file.sv
// Architectural register file at the write-back end of the pipeline.
// Two bypassed combinational read ports, written-valid tracking, write count.
module wb_reg_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  wb_reg_file_if.slave bus
);

  localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] valid_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                we;

  // Register 0 and addresses past the array are never real storage.
  function automatic logic live(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} < NR);
  endfunction

  function automatic logic [DATA_W:0] rd_port(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W:0] r;
    r = '0;
    if (live(a)) begin
      if (bus.RegWrite_in && (a == bus.RdAddr_in))
        r = {1'b0, bus.WrData_in};
      else
        r = {~valid_q[a], regs_q[a]};
    end
    return r;
  endfunction

  assign we    = bus.RegWrite_in && live(bus.RdAddr_in);
  assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else if (we) begin
      regs_q[bus.RdAddr_in]  <= bus.WrData_in;
      valid_q[bus.RdAddr_in] <= 1'b1;
      cnt_q                  <= cnt_d;
    end
  end

  logic [DATA_W:0] rs_r;
  logic [DATA_W:0] rt_r;

  always_comb begin
    rs_r = rd_port(bus.RsAddr_in);
    rt_r = rd_port(bus.RtAddr_in);
  end

  assign bus.RsData_out   = rs_r[DATA_W-1:0];
  assign bus.RsUninit_out = rs_r[DATA_W];
  assign bus.RtData_out   = rt_r[DATA_W-1:0];
  assign bus.RtUninit_out = rt_r[DATA_W];
  assign bus.WrCount_out  = cnt_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed bench for wb_reg_file: default build plus a CNT_W=4 build
// used for the saturating write counter.
module tb_wb_reg_file;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  wb_reg_file_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus ();
  wb_reg_file_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

  wb_reg_file #(
    .DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wb_reg_file #(
    .DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .CNT_W(4)
  ) dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.RegWrite_in = 1'b0;
    bus.RdAddr_in   = '0;
    bus.WrData_in   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.RsAddr_in = 5'd5;
    bus.RtAddr_in = 5'd0;
    #1;
    checks += 5;
    if (bus.RsData_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_rs_data got=%h exp=0", bus.RsData_out);
    end
    if (bus.RsUninit_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_rs_uninit got=%b exp=1", bus.RsUninit_out);
    end
    if (bus.RtData_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_rt_data got=%h exp=0", bus.RtData_out);
    end
    if (bus.RtUninit_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_rt_uninit got=%b exp=0", bus.RtUninit_out);
    end
    if (bus.WrCount_out !== 16'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", bus.WrCount_out);
    end
  endtask

  task automatic test_write_read();
    bus.RegWrite_in = 1'b1;
    bus.RdAddr_in   = 5'd8;
    bus.WrData_in   = 32'hDEADBEEF;
    bus.RsAddr_in   = 5'd1;
    bus.RtAddr_in   = 5'd2;
    tick();
    idle();
    bus.RsAddr_in = 5'd8;
    bus.RtAddr_in = 5'd8;
    #1;
    checks += 5;
    if (bus.RsData_out !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_rs_data got=%h exp=deadbeef", bus.RsData_out);
    end
    if (bus.RtData_out !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_rt_data got=%h exp=deadbeef", bus.RtData_out);
    end
    if (bus.RsUninit_out !== 1'b0) begin
      failures++;
      $display("FAIL wr_rs_uninit got=%b exp=0", bus.RsUninit_out);
    end
    if (bus.RtUninit_out !== 1'b0) begin
      failures++;
      $display("FAIL wr_rt_uninit got=%b exp=0", bus.RtUninit_out);
    end
    if (bus.WrCount_out !== 16'd1) begin
      failures++;
      $display("FAIL wr_count got=%0d exp=1", bus.WrCount_out);
    end
  endtask

  task automatic test_bypass();
    bus.RegWrite_in = 1'b1;
    bus.RdAddr_in   = 5'd3;
    bus.WrData_in   = 32'h12345678;
    bus.RsAddr_in   = 5'd3;
    bus.RtAddr_in   = 5'd4;
    #1;
    checks += 4;
    if (bus.RsData_out !== 32'h12345678) begin
      failures++;
      $display("FAIL byp_rs_data got=%h exp=12345678", bus.RsData_out);
    end
    if (bus.RsUninit_out !== 1'b0) begin
      failures++;
      $display("FAIL byp_rs_uninit got=%b exp=0", bus.RsUninit_out);
    end
    if (bus.RtUninit_out !== 1'b1) begin
      failures++;
      $display("FAIL byp_rt_uninit got=%b exp=1", bus.RtUninit_out);
    end
    if (bus.RtData_out !== 32'h0) begin
      failures++;
      $display("FAIL byp_rt_data got=%h exp=0", bus.RtData_out);
    end
    tick();
    idle();
    #1;
    checks += 3;
    if (bus.RsData_out !== 32'h12345678) begin
      failures++;
      $display("FAIL byp_next_data got=%h exp=12345678", bus.RsData_out);
    end
    if (bus.RsUninit_out !== 1'b0) begin
      failures++;
      $display("FAIL byp_next_uninit got=%b exp=0", bus.RsUninit_out);
    end
    if (bus.WrCount_out !== 16'd2) begin
      failures++;
      $display("FAIL byp_count got=%0d exp=2", bus.WrCount_out);
    end
  endtask

  task automatic test_reg0();
    bus.RegWrite_in = 1'b1;
    bus.RdAddr_in   = 5'd0;
    bus.WrData_in   = 32'hFFFFFFFF;
    bus.RsAddr_in   = 5'd0;
    bus.RtAddr_in   = 5'd0;
    #1;
    checks++;
    if (bus.RsData_out !== 32'h0) begin
      failures++;
      $display("FAIL r0_bypass got=%h exp=0", bus.RsData_out);
    end
    tick();
    // Disabled write to reg 9 must leave it untouched.
    bus.RegWrite_in = 1'b0;
    bus.RdAddr_in   = 5'd9;
    bus.WrData_in   = 32'hCAFEF00D;
    tick();
    idle();
    bus.RsAddr_in = 5'd0;
    bus.RtAddr_in = 5'd9;
    #1;
    checks += 5;
    if (bus.RsData_out !== 32'h0) begin
      failures++;
      $display("FAIL r0_data got=%h exp=0", bus.RsData_out);
    end
    if (bus.RsUninit_out !== 1'b0) begin
      failures++;
      $display("FAIL r0_uninit got=%b exp=0", bus.RsUninit_out);
    end
    if (bus.WrCount_out !== 16'd2) begin
      failures++;
      $display("FAIL r0_count got=%0d exp=2", bus.WrCount_out);
    end
    if (bus.RtData_out !== 32'h0) begin
      failures++;
      $display("FAIL nowe_data got=%h exp=0", bus.RtData_out);
    end
    if (bus.RtUninit_out !== 1'b1) begin
      failures++;
      $display("FAIL nowe_uninit got=%b exp=1", bus.RtUninit_out);
    end
  endtask

  task automatic test_rewrite_same_addr();
    bus.RegWrite_in = 1'b1;
    bus.RdAddr_in   = 5'd8;
    bus.WrData_in   = 32'h0BADF00D;
    bus.RsAddr_in   = 5'd8;
    bus.RtAddr_in   = 5'd8;
    #1;
    checks += 2;
    if (bus.RsData_out !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL dual_rs got=%h exp=0badf00d", bus.RsData_out);
    end
    if (bus.RtData_out !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL dual_rt got=%h exp=0badf00d", bus.RtData_out);
    end
    tick();
    idle();
    #1;
    checks += 3;
    if (bus.RsData_out !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL rewr_data got=%h exp=0badf00d", bus.RsData_out);
    end
    if (bus.RsUninit_out !== 1'b0) begin
      failures++;
      $display("FAIL rewr_uninit got=%b exp=0", bus.RsUninit_out);
    end
    if (bus.WrCount_out !== 16'd3) begin
      failures++;
      $display("FAIL rewr_count got=%0d exp=3", bus.WrCount_out);
    end
  endtask

  task automatic test_reset_collision();
    rst             = 1'b1;
    bus.RegWrite_in = 1'b1;
    bus.RdAddr_in   = 5'd7;
    bus.WrData_in   = 32'hA5A5A5A5;
    bus.RsAddr_in   = 5'd3;
    bus.RtAddr_in   = 5'd7;
    #1;
    checks += 2;
    if (bus.RsData_out !== 32'h12345678) begin
      failures++;
      $display("FAIL rstrd_rs got=%h exp=12345678", bus.RsData_out);
    end
    if (bus.RtData_out !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL rstrd_byp got=%h exp=a5a5a5a5", bus.RtData_out);
    end
    tick();
    rst = 1'b0;
    idle();
    bus.RsAddr_in = 5'd7;
    bus.RtAddr_in = 5'd3;
    #1;
    checks += 5;
    if (bus.RsData_out !== 32'h0) begin
      failures++;
      $display("FAIL coll_data got=%h exp=0", bus.RsData_out);
    end
    if (bus.RsUninit_out !== 1'b1) begin
      failures++;
      $display("FAIL coll_uninit got=%b exp=1", bus.RsUninit_out);
    end
    if (bus.WrCount_out !== 16'd0) begin
      failures++;
      $display("FAIL coll_count got=%0d exp=0", bus.WrCount_out);
    end
    if (bus.RtData_out !== 32'h0) begin
      failures++;
      $display("FAIL coll_r3 got=%h exp=0", bus.RtData_out);
    end
    if (bus.RtUninit_out !== 1'b1) begin
      failures++;
      $display("FAIL coll_r3u got=%b exp=1", bus.RtUninit_out);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    bus4.RsAddr_in = 5'd1;
    bus4.RtAddr_in = 5'd1;
    for (int i = 1; i <= 20; i++) begin
      bus4.RegWrite_in = 1'b1;
      bus4.RdAddr_in   = 5'd1;
      bus4.WrData_in   = 32'(i);
      tick();
      exp_cnt = (i >= 15) ? 4'd15 : 4'(i);
      checks++;
      if (bus4.WrCount_out !== exp_cnt) begin
        failures++;
        $display("FAIL sat_count_%0d got=%0d exp=%0d",
                 i, bus4.WrCount_out, exp_cnt);
      end
    end
    bus4.RegWrite_in = 1'b0;
    #1;
    checks += 2;
    if (bus4.RsData_out !== 32'd20) begin
      failures++;
      $display("FAIL sat_data got=%0d exp=20", bus4.RsData_out);
    end
    if (bus4.WrCount_out !== 4'd15) begin
      failures++;
      $display("FAIL sat_hold got=%0d exp=15", bus4.WrCount_out);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    bus.RsAddr_in    = '0;
    bus.RtAddr_in    = '0;
    bus4.RegWrite_in = 1'b0;
    bus4.RdAddr_in   = '0;
    bus4.WrData_in   = '0;
    bus4.RsAddr_in   = '0;
    bus4.RtAddr_in   = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_reg0();
    test_rewrite_same_addr();
    test_reset_collision();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
